// File: rtl/pmem_burst_adapter.sv
// Cache-line to memory-burst adapter: one 256-bit line <-> four 64-bit bursts.
// Optional watchdog timeout enabled by defining PMEM_TIMEOUT_EN.
module pmem_burst_adapter #(
    parameter int s_line         = 256,
    parameter int s_burst        = 64,
    parameter int s_offset       = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [s_line-1:0]   line_i,
    output logic [s_line-1:0]   line_o,
    input  logic [31:0]         address_i,
    input  logic                read_i,
    input  logic                write_i,
    output logic                resp_o,
    output logic                err_o,
    input  logic [s_burst-1:0]  burst_i,
    output logic [s_burst-1:0]  burst_o,
    output logic [31:0]         address_o,
    output logic                read_o,
    output logic                write_o,
    input  logic                resp_i
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t              state_reg;
    logic [1:0]          cnt_reg;
    logic [s_line-1:0]   line_reg;
    logic [s_line-1:0]   wline_reg;
    logic [31:0]         addr_reg;

`ifdef PMEM_TIMEOUT_EN
    logic [7:0]          wdog_reg;
    logic                err_reg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 2'd0;
            line_reg  <= '0;
            wline_reg <= '0;
            addr_reg  <= '0;
`ifdef PMEM_TIMEOUT_EN
            wdog_reg  <= 8'd0;
            err_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    cnt_reg <= 2'd0;
`ifdef PMEM_TIMEOUT_EN
                    wdog_reg <= 8'd0;
                    err_reg  <= 1'b0;
`endif
                    // A simultaneous read and write request is served as a write.
                    if (write_i) begin
                        addr_reg  <= address_i;
                        wline_reg <= line_i;
                        state_reg <= WRITE;
                    end else if (read_i) begin
                        addr_reg  <= address_i;
                        state_reg <= READ;
                    end
                end
                READ, WRITE: begin
                    if (resp_i) begin
                        if (state_reg == READ)
                            line_reg[s_burst*cnt_reg +: s_burst] <= burst_i;
                        cnt_reg <= cnt_reg + 2'd1;
                        if (cnt_reg == 2'd3)
                            state_reg <= DONE;
`ifdef PMEM_TIMEOUT_EN
                        wdog_reg <= 8'd0;
                    end else if (wdog_reg == 8'(TIMEOUT_CYCLES - 1)) begin
                        state_reg <= DONE;
                        err_reg   <= 1'b1;
                    end else begin
                        wdog_reg <= wdog_reg + 8'd1;
`endif
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign read_o    = (state_reg == READ);
    assign write_o   = (state_reg == WRITE);
    assign resp_o    = (state_reg == DONE);
    assign line_o    = line_reg;
    assign burst_o   = wline_reg[s_burst*cnt_reg +: s_burst];
    // Line offset bits are forced low so memory always sees an aligned line address.
    assign address_o = addr_reg & ~32'((64'd1 << s_offset) - 64'd1);

`ifdef PMEM_TIMEOUT_EN
    assign err_o = err_reg && (state_reg == DONE);
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_burst_adapter.sv
// Directed self-checking bench for pmem_burst_adapter.
// Define PMEM_TIMEOUT_EN to also exercise the watchdog with TIMEOUT_CYCLES=16.
module tb_pmem_burst_adapter;

    logic         clk;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic         err_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int checks = 0;
    int errors = 0;

    pmem_burst_adapter #(.TIMEOUT_CYCLES(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .err_o     (err_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled and inputs changed at the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    localparam logic [63:0] BA = 64'hAAAA_0000_0000_000A;
    localparam logic [63:0] BB = 64'hBBBB_0000_0000_000B;
    localparam logic [63:0] BC = 64'hCCCC_0000_0000_000C;
    localparam logic [63:0] BD = 64'hDDDD_0000_0000_000D;
    localparam logic [63:0] W1 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] W2 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] W3 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] W4 = 64'h4444_4444_4444_4444;

    logic [63:0] wv [4];
    logic [63:0] rv [4];

    initial begin
        wv[0] = W1; wv[1] = W2; wv[2] = W3; wv[3] = W4;
        rst = 1'b1; read_i = 1'b1; write_i = 1'b0; resp_i = 1'b0;
        line_i = '0; address_i = 32'h0; burst_i = '0;

        // Reset held for two cycles with a pending read.
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_read_o", 256'(read_o), 256'(0));
            chk("rst_write_o", 256'(write_o), 256'(0));
            chk("rst_resp_o", 256'(resp_o), 256'(0));
            chk("rst_err_o", 256'(err_o), 256'(0));
            chk("rst_address_o", 256'(address_o), 256'(0));
            chk("rst_burst_o", 256'(burst_o), 256'(0));
            chk("rst_line_o", line_o, 256'(0));
        end
        rst = 1'b0; read_i = 1'b0;
        step();
        chk("idle_read_o", 256'(read_o), 256'(0));

        // Read with two idle cycles before four back-to-back bursts.
        read_i = 1'b1; address_i = 32'h1234_567F;
        step();
        chk("rd_read_o", 256'(read_o), 256'(1));
        chk("rd_address_o", 256'(address_o), 256'(32'h1234_5660));
        step();
        chk("rd_gap_read_o", 256'(read_o), 256'(1));
        chk("rd_gap_line_o", line_o, 256'(0));
        resp_i = 1'b1; burst_i = BA; step();
        chk("rd_resp_o_mid", 256'(resp_o), 256'(0));
        burst_i = BB; step();
        burst_i = BC; step();
        burst_i = BD; step();
        chk("rd_resp_o", 256'(resp_o), 256'(1));
        chk("rd_read_o_done", 256'(read_o), 256'(0));
        chk("rd_line_o", line_o, {BD, BC, BB, BA});
        $display("TXN read addr=%h line=%h", address_o, line_o);
        read_i = 1'b0; resp_i = 1'b0; burst_i = '0;
        step();
        chk("rd_resp_pulse", 256'(resp_o), 256'(0));
        chk("rd_line_hold", line_o, {BD, BC, BB, BA});

        // Write with a one-cycle gap between memory acknowledgements.
        write_i = 1'b1; address_i = 32'hCAFE_0020; line_i = {W4, W3, W2, W1};
        step();
        for (int i = 0; i < 4; i++) begin
            chk("wr_write_o", 256'(write_o), 256'(1));
            chk("wr_burst_o", 256'(burst_o), 256'(wv[i]));
            chk("wr_resp_o_mid", 256'(resp_o), 256'(0));
            resp_i = 1'b1; step();
            if (i < 3) begin
                chk("wr_gap_burst_o", 256'(burst_o), 256'(wv[i+1]));
                resp_i = 1'b0; step();
            end
        end
        chk("wr_resp_o", 256'(resp_o), 256'(1));
        chk("wr_err_o", 256'(err_o), 256'(0));
        chk("wr_write_o_done", 256'(write_o), 256'(0));
        chk("wr_address_o", 256'(address_o), 256'(32'hCAFE_0020));
        $display("TXN write addr=%h", address_o);
        write_i = 1'b0; resp_i = 1'b0;
        step();
        chk("wr_resp_pulse", 256'(resp_o), 256'(0));

        // Simultaneous read and write: the write is taken.
        read_i = 1'b1; write_i = 1'b1; address_i = 32'h0000_1000; line_i = {4{64'h5A5A_5A5A_5A5A_5A5A}};
        step();
        for (int i = 0; i < 4; i++) begin
            chk("both_write_o", 256'(write_o), 256'(1));
            chk("both_read_o", 256'(read_o), 256'(0));
            resp_i = 1'b1; step();
        end
        chk("both_resp_o", 256'(resp_o), 256'(1));
        chk("both_line_o_untouched", line_o, {BD, BC, BB, BA});
        $display("TXN both addr=%h", address_o);
        read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
        step();

        // Reset in the middle of a read, then a fresh read.
        read_i = 1'b1; address_i = 32'h0000_2000;
        step();
        resp_i = 1'b1; burst_i = 64'hEEEE; step();
        burst_i = 64'hFFFF; step();
        rst = 1'b1; resp_i = 1'b0;
        step();
        chk("abort_read_o", 256'(read_o), 256'(0));
        chk("abort_resp_o", 256'(resp_o), 256'(0));
        chk("abort_line_o", line_o, 256'(0));
        $display("TXN abort");
        rst = 1'b0; read_i = 1'b0;
        step();
        chk("abort_idle_resp_o", 256'(resp_o), 256'(0));
        rv[0] = 64'h0123_4567_89AB_CDEF; rv[1] = 64'h1;
        rv[2] = 64'hFFFF_FFFF_FFFF_FFFF; rv[3] = 64'h8000_0000_0000_0000;
        read_i = 1'b1; address_i = 32'h0000_3004;
        step();
        chk("rd2_read_o", 256'(read_o), 256'(1));
        chk("rd2_address_o", 256'(address_o), 256'(32'h0000_3000));
        for (int i = 0; i < 4; i++) begin
            resp_i = 1'b1; burst_i = rv[i]; step();
        end
        chk("rd2_resp_o", 256'(resp_o), 256'(1));
        chk("rd2_line_o", line_o, {rv[3], rv[2], rv[1], rv[0]});
        $display("TXN read2 addr=%h line=%h", address_o, line_o);
        read_i = 1'b0; resp_i = 1'b0;
        step();
        chk("rd2_resp_pulse", 256'(resp_o), 256'(0));

`ifdef PMEM_TIMEOUT_EN
        // Read with no memory response at all.
        begin
            int n;
            read_i = 1'b1; address_i = 32'h0000_4000;
            step();
            n = 0;
            while (read_o && n < 40) begin
                n++;
                step();
            end
            chk("to_cycles", 256'(n), 256'(16));
            chk("to_resp_o", 256'(resp_o), 256'(1));
            chk("to_err_o", 256'(err_o), 256'(1));
            $display("TXN timeout cycles=%0d", n);
            read_i = 1'b0;
            step();
            chk("to_idle_resp_o", 256'(resp_o), 256'(0));
            chk("to_idle_err_o", 256'(err_o), 256'(0));
            chk("to_idle_read_o", 256'(read_o), 256'(0));
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
